// File: rtl/gf10_pkg.sv
// rtl/gf10_pkg.sv - shared GF(2^10) field constants and element type
package gf10_pkg;

  localparam int          GF_LEN  = 10;
  localparam logic [10:0] GF_POLY = 11'h409;

  typedef logic [GF_LEN-1:0] gf10_t;

  localparam gf10_t GF_ZERO = 10'h000;
  localparam gf10_t GF_ONE  = 10'h001;

endpackage : gf10_pkg

// File: rtl/gf_mult_2_10_core.sv
// rtl/gf_mult_2_10_core.sv - combinational GF(2^10) AND/XOR product with polynomial reduction
module gf_mult_2_10_core
  import gf10_pkg::*;
#(
  parameter logic [10:0] POLY = GF_POLY
) (
  input  gf10_t a,
  input  gf10_t b,
  output gf10_t out
);

  // Raw carry-less product of degree <= 18.
  logic [18:0] raw_c;

  // Reduced remainder, bits [18:10] cleared once folding completes.
  logic [18:0] red_c;

  // Partial-product array: every a[i]&b[j] lands on x^(i+j), summed with XOR.
  always_comb begin
    raw_c = '0;
    for (int i = 0; i < GF_LEN; i++) begin
      for (int j = 0; j < GF_LEN; j++) begin
        raw_c[i+j] = raw_c[i+j] ^ (a[i] & b[j]);
      end
    end
  end

  // Fold top bits down using x^10 = POLY[9:0]; going high-to-low means any bit
  // that a fold pushes back above x^9 is still visited by a later iteration.
  always_comb begin
    red_c = raw_c;
    for (int k = 18; k >= GF_LEN; k--) begin
      for (int m = 0; m < GF_LEN; m++) begin
        if (POLY[m]) begin
          red_c[k-GF_LEN+m] = red_c[k-GF_LEN+m] ^ red_c[k];
        end
      end
      red_c[k] = 1'b0;
    end
  end

  assign out = red_c[GF_LEN-1:0];

endmodule : gf_mult_2_10_core

// File: rtl/gf_mult_2_10.sv
// rtl/gf_mult_2_10.sv - GF(2^10) multiplier with combinational and registered product
module gf_mult_2_10
  import gf10_pkg::*;
#(
  parameter int          GF_LEN = 10,
  parameter logic [10:0] POLY   = 11'h409
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [GF_LEN-1:0] a,
  input  logic [GF_LEN-1:0] b,
  output logic [GF_LEN-1:0] out,
  output logic [GF_LEN-1:0] out_q
);

  gf10_t prod_d;
  gf10_t prod_q;

  gf_mult_2_10_core #(
    .POLY (POLY)
  ) u_core (
    .a   (a),
    .b   (b),
    .out (prod_d)
  );

  // Capture the product when enabled; reset clears it without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= GF_ZERO;
    end else if (en) begin
      prod_q <= prod_d;
    end
  end

  assign out   = prod_d;
  assign out_q = prod_q;

endmodule : gf_mult_2_10

// File: tb/tb_gf_mult_2_10.sv
// tb/tb_gf_mult_2_10.sv - self-checking bench for gf_mult_2_10
module tb_gf_mult_2_10;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [9:0] a;
  logic [9:0] b;
  logic [9:0] out;
  logic [9:0] out_q;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [9:0] a;
    logic [9:0] b;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[10];

  gf_mult_2_10 #(
    .GF_LEN (10),
    .POLY   (11'h409)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .a     (a),
    .b     (b),
    .out   (out),
    .out_q (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift-and-add reference: walk b's bits while multiplying a by x each step.
  function automatic logic [9:0] ref_mul(input logic [9:0] x, input logic [9:0] y);
    logic [10:0] acc;
    logic [10:0] sh;
    acc = '0;
    sh  = {1'b0, x};
    for (int i = 0; i < 10; i++) begin
      if (y[i]) acc = acc ^ sh;
      sh = sh << 1;
      if (sh[10]) sh = sh ^ 11'h409;
    end
    return acc[9:0];
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
    end
  endtask

  initial begin
    logic [9:0] cur;
    logic [9:0] p_ab;
    int         early;
    logic [9:0] step1;

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{10'h3FF, 10'h001, 10'h3FF};
    vecs[1] = '{10'h3FF, 10'h000, 10'h000};
    vecs[2] = '{10'h001, 10'h002, 10'h002};
    vecs[3] = '{10'h200, 10'h002, 10'h009};
    vecs[4] = '{10'h200, 10'h200, 10'h112};
    vecs[5] = '{10'h100, 10'h004, 10'h009};
    vecs[6] = '{10'h003, 10'h003, 10'h005};
    vecs[7] = '{10'h200, 10'h004, 10'h012};
    vecs[8] = '{10'h155, 10'h001, 10'h155};
    vecs[9] = '{10'h000, 10'h2AA, 10'h000};

    // Reset asserted from time zero, no clock edge yet.
    rst_n = 1'b0;
    en    = 1'b0;
    a     = '0;
    b     = '0;
    #2;
    check("reset_no_edge", out_q, 10'h000);

    // Directed combinational vectors.
    for (int i = 0; i < 10; i++) begin
      a = vecs[i].a;
      b = vecs[i].b;
      #1;
      check($sformatf("vec%0d", i), out, vecs[i].exp);
    end

    // Random pairs against the reference, plus commutativity.
    for (int i = 0; i < 100000; i++) begin
      a = 10'($urandom);
      b = 10'($urandom);
      #1;
      p_ab = out;
      check("rand_ref", p_ab, ref_mul(a, b));
      {a, b} = {b, a};
      #1;
      check("rand_comm", out, p_ab);
    end

    // Field order of alpha.
    cur   = 10'h001;
    early = 0;
    step1 = '0;
    for (int s = 1; s <= 1023; s++) begin
      a = cur;
      b = 10'h002;
      #1;
      cur = out;
      if (s == 1) step1 = cur;
      if (s < 1023 && cur == 10'h001) early++;
    end
    check("order_step1", step1, 10'h002);
    check("order_early_return", 10'(early), 10'h000);
    check("order_1023", cur, 10'h001);

    // Reset held with en=1 across an edge keeps out_q at zero.
    @(negedge clk);
    en = 1'b1;
    a  = 10'h200;
    b  = 10'h002;
    @(posedge clk);
    #1;
    check("reset_hold_edge", out_q, 10'h000);

    // Release and load.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("load_x10", out_q, 10'h009);

    // Enable low: out_q holds, out follows.
    @(negedge clk);
    en = 1'b0;
    a  = 10'h123;
    b  = 10'h045;
    @(posedge clk);
    #1;
    check("hold_q", out_q, 10'h009);
    check("hold_comb", out, ref_mul(10'h123, 10'h045));

    // Load x^18.
    @(negedge clk);
    en = 1'b1;
    a  = 10'h200;
    b  = 10'h200;
    @(posedge clk);
    #1;
    check("load_x18", out_q, 10'h112);

    // Async reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_q", out_q, 10'h000);
    check("async_reset_comb", out, 10'h112);

    // Release with en=0: no load until en goes high.
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
    @(posedge clk);
    #1;
    check("post_release_hold", out_q, 10'h000);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    check("post_release_load", out_q, 10'h112);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_gf_mult_2_10
